// File: rtl/ins_block_memory.sv
// Instruction backing memory: serves 4-word cache-line refills over a
// read/busywait handshake, with a word-wide preload port for the program image.
module ins_block_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 4,
    parameter int ADDR_W      = 28
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           read,
    input  logic [ADDR_W-1:0]              address,
    output logic [127:0]                   readdata,
    output logic                           busywait,
    input  logic                           prog_write,
    input  logic [$clog2(DEPTH_WORDS)-1:0] prog_addr,
    input  logic [31:0]                    prog_data
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FETCH = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Backing store; deliberately not reset so the program image survives reset.
    logic [31:0] mem [DEPTH_WORDS];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] line_q, line_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [1:0]        beat_q, beat_d;
    logic [3:0][31:0]  rdata_q, rdata_d;

    // Word index = (line*4 + beat) mod DEPTH_WORDS: just the low AW bits of {line, beat}.
    logic [ADDR_W+1:0] word_full;
    logic [AW-1:0]     word_idx;
    logic [31:0]       mem_rd;
    logic              unused_word_hi;

    assign word_full      = {line_q, beat_q};
    assign word_idx       = word_full[AW-1:0];
    assign unused_word_hi = ^word_full;
    // Read is taken from the pre-edge contents, so a same-edge preload write
    // to the fetched word is seen only by a later refill.
    assign mem_rd         = mem[word_idx];

    // Preload write port, active in every state.
    always_ff @(posedge clock) begin
        if (prog_write) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // State and datapath registers; reset aborts any refill in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            line_q  <= '0;
            wait_q  <= '0;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state and datapath updates; dropping read in WAIT/FETCH aborts to IDLE.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (read) begin
                    line_d  = address;
                    wait_d  = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!read) begin
                    state_d = S_IDLE;
                end else if (wait_q == '0) begin
                    beat_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_FETCH: begin
                if (!read) begin
                    state_d = S_IDLE;
                end else begin
                    rdata_d[beat_q] = mem_rd;
                    beat_d          = beat_q + 1'b1;
                    if (beat_q == 2'd3) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake output: high as soon as read rises in IDLE, low only in DONE or idle.
    always_comb begin
        busywait = 1'b0;
        unique case (state_q)
            S_IDLE:  busywait = read;
            S_WAIT:  busywait = 1'b1;
            S_FETCH: busywait = 1'b1;
            S_DONE:  busywait = 1'b0;
            default: busywait = 1'b0;
        endcase
    end

    assign readdata = rdata_q;

endmodule

// File: tb/tb_ins_block_memory.sv
// Directed bench for ins_block_memory: refill latency, back-to-back requests,
// reset abort, read-drop abort, address wrap and preload read-before-write.
module tb_ins_block_memory;

    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 4;
    localparam int ADDR_W      = 28;
    localparam int AW          = 10;

    logic              clock = 1'b0;
    logic              reset;
    logic              read;
    logic [ADDR_W-1:0] address;
    logic [127:0]      readdata;
    logic              busywait;
    logic              prog_write;
    logic [AW-1:0]     prog_addr;
    logic [31:0]       prog_data;

    int checks   = 0;
    int failures = 0;
    int n;

    localparam logic [127:0] LINE40 = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    localparam logic [127:0] LINE41 = {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004};
    localparam logic [127:0] LINETP = {32'hC0000003, 32'hC0000002, 32'hC0000001, 32'hC0000000};
    localparam logic [127:0] PART40 = {32'hA0000007, 32'hA0000006, 32'hA0000001, 32'hA0000000};
    localparam logic [127:0] NEW40  = {32'hA0000003, 32'hDEADBEEF, 32'hA0000001, 32'hA0000000};

    ins_block_memory #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .LATENCY    (LATENCY),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .read      (read),
        .address   (address),
        .readdata  (readdata),
        .busywait  (busywait),
        .prog_write(prog_write),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; writes one word on the following posedge.
    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        prog_write = 1'b1;
        prog_addr  = a;
        prog_data  = d;
        @(negedge clock);
        prog_write = 1'b0;
    endtask

    // Counts negedges until busywait is low, bounded so a stuck DUT still ends.
    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (busywait && cnt < 40);
    endtask

    initial begin
        reset      = 1'b0;
        read       = 1'b0;
        address    = '0;
        prog_write = 1'b0;
        prog_addr  = '0;
        prog_data  = '0;
        repeat (2) @(negedge clock);
        chk("reset_busywait", 128'(busywait), 128'd0);
        chk("reset_readdata", readdata, 128'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_no_read_busywait", 128'(busywait), 128'd0);

        for (int i = 0; i < 8; i++) preload(AW'(32'h100 + i), 32'hA0000000 + i);
        for (int i = 0; i < 4; i++) preload(AW'(32'h3FC + i), 32'hC0000000 + i);

        // Basic refill of line 0x40.
        read    = 1'b1;
        address = 28'h40;
        #1;
        chk("req_busywait_comb", 128'(busywait), 128'd1);
        wait_done(n);
        chk("refill1_latency", 128'(n), 128'd9);
        chk("refill1_data", readdata, LINE40);

        // Back-to-back: hold read through DONE, new address 0x41.
        address = 28'h41;
        wait_done(n);
        chk("b2b_latency", 128'(n), 128'd10);
        chk("b2b_data", readdata, LINE41);
        read = 1'b0;
        @(negedge clock);
        chk("idle_after_done_busywait", 128'(busywait), 128'd0);
        chk("idle_readdata_stable", readdata, LINE41);

        // Reset while beat 2 is about to be fetched.
        read    = 1'b1;
        address = 28'h40;
        repeat (7) @(negedge clock);
        chk("fetch_partial_data", readdata, PART40);
        reset = 1'b0;
        read  = 1'b0;
        #1;
        chk("async_reset_busywait", 128'(busywait), 128'd0);
        chk("async_reset_readdata", readdata, 128'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        read    = 1'b1;
        address = 28'h40;
        wait_done(n);
        chk("post_reset_latency", 128'(n), 128'd9);
        chk("post_reset_data", readdata, LINE40);
        read = 1'b0;
        @(negedge clock);

        // Drop read during WAIT.
        read    = 1'b1;
        address = 28'h41;
        repeat (2) @(negedge clock);
        read = 1'b0;
        #1;
        chk("wait_busywait_held", 128'(busywait), 128'd1);
        @(negedge clock);
        chk("wait_abort_busywait", 128'(busywait), 128'd0);
        chk("wait_abort_readdata", readdata, LINE40);
        read = 1'b1;
        wait_done(n);
        chk("after_abort_latency", 128'(n), 128'd9);
        chk("after_abort_data", readdata, LINE41);
        read = 1'b0;
        @(negedge clock);

        // Address wrap to the top line; address change mid-refill ignored.
        read    = 1'b1;
        address = 28'h1FF;
        @(negedge clock);
        address = 28'h0;
        wait_done(n);
        chk("wrap_latency", 128'(n + 1), 128'd9);
        chk("wrap_data", readdata, LINETP);
        read = 1'b0;
        @(negedge clock);

        // Preload to word 0x102 on the same edge that captures beat 2.
        read    = 1'b1;
        address = 28'h40;
        repeat (7) @(negedge clock);
        preload(AW'(32'h102), 32'hDEADBEEF);
        wait_done(n);
        chk("rbw_latency", 128'(n + 8), 128'd9);
        chk("rbw_old_data", readdata, LINE40);
        read = 1'b0;
        @(negedge clock);
        read = 1'b1;
        wait_done(n);
        chk("rbw_new_latency", 128'(n), 128'd9);
        chk("rbw_new_data", readdata, NEW40);
        read = 1'b0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
